// File: rtl/operand_fwd_unit_pkg.sv
// Shared types for the decode-stage forwarding unit: in-flight destination tag entries.
package operand_fwd_unit_pkg;

   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;

   typedef struct packed {
      logic              we;
      logic [AW_DEF-1:0] rd;
   } fwd_entry_t;

   localparam fwd_entry_t BUBBLE = '{we: 1'b0, rd: '0};

   // x0 never produces a forwardable value, so such writes are tracked as non-writing
   function automatic fwd_entry_t mkEntry(input logic we, input logic [AW_DEF-1:0] rd);
      fwd_entry_t e;
      e.we = we && (rd != '0);
      e.rd = rd;
      return e;
   endfunction

endpackage

// File: rtl/operand_fwd_unit_if.sv
// Decode-side bundle of the forwarding unit: read ports, issue info, stage results and outputs.
interface operand_fwd_unit_if #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int NRP    = 2,
   parameter int NSTAGE = 3
);
   logic [NRP*AW-1:0]      id_ra;
   logic [NRP*XLEN-1:0]    rf_rdata;
   logic                   issue_valid;
   logic [AW-1:0]          issue_rd;
   logic                   issue_we;
   logic                   flush;
   logic [NSTAGE*XLEN-1:0] stg_data;
   logic [NSTAGE-1:0]      stg_ready;
   logic [NRP*XLEN-1:0]    fwd_data;
   logic [NRP-1:0]         fwd_hit;
   logic                   stall;
   logic [31:0]            stall_cnt;

   modport master (
      output id_ra, rf_rdata, issue_valid, issue_rd, issue_we, flush, stg_data, stg_ready,
      input  fwd_data, fwd_hit, stall, stall_cnt
   );

   modport slave (
      input  id_ra, rf_rdata, issue_valid, issue_rd, issue_we, flush, stg_data, stg_ready,
      output fwd_data, fwd_hit, stall, stall_cnt
   );
endinterface

// File: rtl/operand_fwd_unit_fwd_port_sel.sv
// One read port's operand select: youngest matching in-flight stage, else register file.
module fwd_port_sel
   import operand_fwd_unit_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int AW     = AW_DEF,
   parameter int NSTAGE = 3
) (
   input  logic [AW-1:0]          ra_i,
   input  logic [XLEN-1:0]        rfData_i,
   input  fwd_entry_t [NSTAGE-1:0] entries_i,
   input  logic [NSTAGE*XLEN-1:0] stgData_i,
   input  logic [NSTAGE-1:0]      stgReady_i,
   output logic [XLEN-1:0]        data_o,
   output logic                   hit_o,
   output logic                   stall_o
);

   // Walk oldest to youngest so the youngest match overwrites, and an older ready
   // producer can never mask a younger one that is still busy.
   always_comb begin
      data_o  = (ra_i == '0) ? '0 : rfData_i;
      hit_o   = 1'b0;
      stall_o = 1'b0;
      for (int s = NSTAGE - 1; s >= 0; s--) begin
         if (entries_i[s].we && (entries_i[s].rd == ra_i) && (ra_i != '0)) begin
            data_o  = stgData_i[s*XLEN +: XLEN];
            hit_o   = 1'b1;
            stall_o = !stgReady_i[s];
         end
      end
   end

endmodule

// File: rtl/operand_fwd_unit.sv
// Operand forwarding and load-use interlock: tracks in-flight destination tags and
// steers each decode read port to the youngest producer, stalling when it is not ready.
module operand_fwd_unit
   import operand_fwd_unit_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int AW     = AW_DEF,
   parameter int NRP    = 2,
   parameter int NSTAGE = 3,
   parameter int NKILL  = 1
) (
   input logic               clk,
   input logic               rst,
   operand_fwd_unit_if.slave fwdIf
);

   fwd_entry_t [NSTAGE-1:0] entry_q;
   fwd_entry_t [NSTAGE-1:0] entry_d;
   logic [NRP-1:0]          portStall;
   logic                    stall;
   logic [31:0]             stallCnt_q;

   for (genvar p = 0; p < NRP; p++) begin : gPort
      fwd_port_sel #(
         .XLEN  (XLEN),
         .AW    (AW),
         .NSTAGE(NSTAGE)
      ) uSel (
         .ra_i      (fwdIf.id_ra[p*AW +: AW]),
         .rfData_i  (fwdIf.rf_rdata[p*XLEN +: XLEN]),
         .entries_i (entry_q),
         .stgData_i (fwdIf.stg_data),
         .stgReady_i(fwdIf.stg_ready),
         .data_o    (fwdIf.fwd_data[p*XLEN +: XLEN]),
         .hit_o     (fwdIf.fwd_hit[p]),
         .stall_o   (portStall[p])
      );
   end

   // A flush removes the waiting consumer itself, so it cannot be held
   assign stall           = (|portStall) && !fwdIf.flush;
   assign fwdIf.stall     = stall;
   assign fwdIf.stall_cnt = stallCnt_q;

   // Next tag pipeline: shift toward WB, new issue enters stage 0 unless stalled,
   // and flushed slots take a bubble regardless of what would have moved in.
   always_comb begin
      entry_d    = entry_q;
      entry_d[0] = (fwdIf.issue_valid && !stall) ? mkEntry(fwdIf.issue_we, fwdIf.issue_rd) : BUBBLE;
      for (int s = 1; s < NSTAGE; s++) begin
         entry_d[s] = entry_q[s-1];
      end
      for (int s = 0; s < NKILL; s++) begin
         if (fwdIf.flush) begin
            entry_d[s] = BUBBLE;
         end
      end
   end

   // Reset empties the pipeline (all-zero entries are bubbles) and clears the perf counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q    <= '0;
         stallCnt_q <= '0;
      end else begin
         entry_q <= entry_d;
         if (stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
         end
      end
   end

endmodule
